tlc_phase_sequencer: RTL and testbench
======================================

TLC_PHASE_SEQUENCER -- requirements
Module: tlc_phase_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8: phase-counter width in bits.
REQ-002 SHALL have parameter T_MG, default 7: main-green hold terminal count.
REQ-003 SHALL have parameter T_Y, default 2: yellow and clearance terminal count.
REQ-004 SHALL have parameter T_TG, default 5: turn-green terminal count.
REQ-005 SHALL have parameter T_SG, default 3: side-green terminal count.
REQ-006 SHALL have parameter FLASH_HALF, default 3: flash half-period terminal count.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port side_req, input, 1 bit: side-road vehicle sensor, level.
REQ-010 SHALL have port ped_req, input, 1 bit: pedestrian button, single-cycle pulse or level.
REQ-011 SHALL have port emerg, input, 1 bit: emergency override, level.
REQ-012 SHALL have port flash_en, input, 1 bit: night flash mode, level.
REQ-013 SHALL have ports light_M1, light_M2, light_MT, light_S, output, 3 bits each: lamp codes R=100, Y=010, G=001, dark=000.
REQ-014 SHALL have port phase, output, 3 bits: current state encoding.
REQ-015 SHALL have port ped_walk, output, 1 bit: walk indication.

Function
REQ-016 SHALL implement states MG, M2Y, TG, TY, SG, SY, CLR and FLASH.
REQ-017 SHALL hold each timed state for T+1 cycles (count 0..T), clear count on every state change, and compare only with count==T.
REQ-018 SHALL drive these lamps (M1/M2/MT/S): MG 001/001/100/100, M2Y 001/010/100/100, TG 001/100/001/100, TY 010/100/010/100, SG 100/100/100/001, SY 100/100/100/010, CLR all 100.
REQ-019 SHALL set pend when side_req or ped_req is 1, and clear pend on SG entry; set-and-clear in the same cycle leaves pend=1.
REQ-020 SHALL, at MG count==T_MG, go to M2Y when pend=1; otherwise it SHALL stay in MG and restart count at 0.
REQ-021 SHALL sequence M2Y->TG->TY->SG->SY->MG, each on its terminal count.
REQ-022 SHALL assert ped_walk exactly while in SG.
REQ-023 SHALL, with emerg=1, enter CLR on the next edge from any state and hold there with count frozen at 0.
REQ-024 SHALL, on emerg deassertion, go from CLR to MG with count 0 on the next edge.
REQ-025 SHALL, with flash_en=1 and emerg=0, enter FLASH on the next edge from any state.
REQ-026 SHALL, in FLASH, toggle a blink bit every FLASH_HALF+1 cycles; blink=1 drives M1/M2/MT=010 and S=100; blink=0 drives all 000.
REQ-027 SHALL start the blink bit at 1 on FLASH entry.
REQ-028 SHALL, on flash_en deassertion, go FLASH->CLR, hold CLR for T_Y+1 cycles, then go to MG.
REQ-029 SHALL apply priority rst > emerg > flash_en > normal sequencing.
REQ-030 SHALL decode all outputs only from registered state and blink; no combinational path from input to output.
REQ-031 SHALL decode unused state encodings to CLR lamps and recover to MG on the next edge.
REQ-032 SHALL fail elaboration if any T_* or FLASH_HALF exceeds 2^CNT_W-1.

Reset
REQ-033 SHALL, on rst=1 at an edge, set state=MG, count=0, pend=0 and blink=1.
REQ-034 SHALL drive lamps 001/001/100/100 and ped_walk=0 in the cycle after reset, including reset applied mid-phase.

Structure
REQ-035 SHALL place the state enum, lamp-code constants and the light-vector typedef in shared package tlc_pkg.
REQ-036 SHALL use one sub-module, tlc_phase_timer: a CNT_W counter with clear input and terminal-match output, also reused for the blink half-period.

Verification
REQ-037 SHALL test reset then side_req=1 held: MG 8 cycles, M2Y 3, TG 6, TY 3, SG 4, SY 3; period 27 cycles; ped_walk high 4 cycles.
REQ-038 SHALL test no requests for 40 cycles, then a 1-cycle ped_req pulse: MG stays through 40 cycles, then M2Y at the next MG count==7.
REQ-039 SHALL test emerg=1 at TG count 2: next cycle all lamps 100 and phase=CLR; emerg=0 -> next cycle MG, count 0.
REQ-040 SHALL test flash_en=1: M1 toggles 010/000 every 4 cycles and S toggles 100/000; flash_en=0 -> CLR 3 cycles, then MG.
REQ-041 SHALL test emerg=1 and flash_en=1 together: CLR wins; emerg=0 with flash_en still 1 -> FLASH next edge.
REQ-042 SHALL test rst pulse during SG count 1: next cycle MG, count 0, pend=0, ped_walk=0.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types and lamp codes for the traffic-light phase sequencer.
// Phase encodings are visible on the phase output, so changing them is an interface change.
package tlc_pkg;

  typedef enum logic [2:0] {
    StMg    = 3'd0,
    StM2y   = 3'd1,
    StTg    = 3'd2,
    StTy    = 3'd3,
    StSg    = 3'd4,
    StSy    = 3'd5,
    StClr   = 3'd6,
    StFlash = 3'd7
  } tlc_state_t;

  localparam logic [2:0] LampOff = 3'b000;
  localparam logic [2:0] LampG   = 3'b001;
  localparam logic [2:0] LampY   = 3'b010;
  localparam logic [2:0] LampR   = 3'b100;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;
  } light_t;

  // Any encoding without a lamp pattern of its own shows all-red.
  function automatic light_t decode_lights(tlc_state_t st, logic blink);
    light_t l;
    case (st)
      StMg:    l = '{m1: LampG, m2: LampG, mt: LampR, s: LampR};
      StM2y:   l = '{m1: LampG, m2: LampY, mt: LampR, s: LampR};
      StTg:    l = '{m1: LampG, m2: LampR, mt: LampG, s: LampR};
      StTy:    l = '{m1: LampY, m2: LampR, mt: LampY, s: LampR};
      StSg:    l = '{m1: LampR, m2: LampR, mt: LampR, s: LampG};
      StSy:    l = '{m1: LampR, m2: LampR, mt: LampR, s: LampY};
      StFlash: l = blink ? '{m1: LampY, m2: LampY, mt: LampY, s: LampR}
                         : '{m1: LampOff, m2: LampOff, mt: LampOff, s: LampOff};
      default: l = '{m1: LampR, m2: LampR, mt: LampR, s: LampR};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Free-running up-counter with synchronous clear; match is high while count equals term.
module tlc_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             match
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = clr ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match = (count_q == term);

endmodule

// File: rtl/tlc_phase_sequencer.sv
// Intersection phase sequencer: main/turn/side greens with request latching,
// emergency all-red override and night flash mode. Outputs decode registered state only.
module tlc_phase_sequencer
  import tlc_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned T_MG       = 7,
  parameter int unsigned T_Y        = 2,
  parameter int unsigned T_TG       = 5,
  parameter int unsigned T_SG       = 3,
  parameter int unsigned FLASH_HALF = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  input  logic       emerg,
  input  logic       flash_en,
  output logic [2:0] light_M1,
  output logic [2:0] light_M2,
  output logic [2:0] light_MT,
  output logic [2:0] light_S,
  output logic [2:0] phase,
  output logic       ped_walk
);

  localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;

  if (64'(T_MG) > CntMax || 64'(T_Y) > CntMax || 64'(T_TG) > CntMax ||
      64'(T_SG) > CntMax || 64'(FLASH_HALF) > CntMax) begin : g_param_check
    $error("tlc_phase_sequencer: a terminal count does not fit in CNT_W bits");
  end

  tlc_state_t       state_q, state_d;
  logic             pend_q, pend_d;
  logic             blink_q, blink_d;
  logic             clr_timed_q, clr_timed_d;
  logic [CNT_W-1:0] phase_term;
  logic             phase_match, phase_clr;
  logic             blink_match, blink_clr;
  logic             sg_entry;
  light_t           lights;

  always_comb begin
    unique case (state_q)
      StMg:    phase_term = CNT_W'(T_MG);
      StTg:    phase_term = CNT_W'(T_TG);
      StSg:    phase_term = CNT_W'(T_SG);
      default: phase_term = CNT_W'(T_Y);
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (emerg) begin
      state_d = StClr;
    end else if (flash_en) begin
      state_d = StFlash;
    end else begin
      unique case (state_q)
        StMg:    if (phase_match && pend_q) state_d = StM2y;
        StM2y:   if (phase_match) state_d = StTg;
        StTg:    if (phase_match) state_d = StTy;
        StTy:    if (phase_match) state_d = StSg;
        StSg:    if (phase_match) state_d = StSy;
        StSy:    if (phase_match) state_d = StMg;
        // CLR entered by emergency leaves at once; CLR after flash is held T_Y+1 cycles.
        StClr:   if (!clr_timed_q || phase_match) state_d = StMg;
        StFlash: state_d = StClr;
        default: state_d = StMg;
      endcase
    end
  end

  always_comb begin
    clr_timed_d = 1'b0;
    if (state_q == StFlash && !emerg && !flash_en) begin
      clr_timed_d = 1'b1;
    end else if (state_q == StClr && !emerg && state_d == StClr) begin
      clr_timed_d = clr_timed_q;
    end
  end

  // Clearing on a terminal match also gives the MG restart when nothing is pending.
  assign phase_clr = emerg | flash_en | (state_d != state_q) | phase_match;
  assign sg_entry  = (state_d == StSg) && (state_q != StSg);
  assign pend_d    = (pend_q & ~sg_entry) | side_req | ped_req;

  assign blink_clr = (state_q != StFlash) | blink_match;

  always_comb begin
    if (state_q != StFlash) begin
      blink_d = 1'b1;
    end else if (blink_match) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  tlc_phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (phase_clr),
    .term (phase_term),
    .match(phase_match)
  );

  tlc_phase_timer #(
    .CNT_W(CNT_W)
  ) u_blink_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (blink_clr),
    .term (CNT_W'(FLASH_HALF)),
    .match(blink_match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StMg;
      pend_q      <= 1'b0;
      blink_q     <= 1'b1;
      clr_timed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      blink_q     <= blink_d;
      clr_timed_q <= clr_timed_d;
    end
  end

  assign lights   = decode_lights(state_q, blink_q);
  assign light_M1 = lights.m1;
  assign light_M2 = lights.m2;
  assign light_MT = lights.mt;
  assign light_S  = lights.s;
  assign phase    = state_q;
  assign ped_walk = (state_q == StSg);

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Bench for tlc_phase_sequencer: vector table, directed corner sequences, random vs model.
module tb_tlc_phase_sequencer;
  import tlc_pkg::*;

  localparam int T_MG = 7;
  localparam int T_Y = 2;
  localparam int T_TG = 5;
  localparam int T_SG = 3;
  localparam int FLASH_HALF = 3;

  localparam logic [11:0] L_MG   = 12'b001_001_100_100;
  localparam logic [11:0] L_M2Y  = 12'b001_010_100_100;
  localparam logic [11:0] L_TG   = 12'b001_100_001_100;
  localparam logic [11:0] L_TY   = 12'b010_100_010_100;
  localparam logic [11:0] L_SG   = 12'b100_100_100_001;
  localparam logic [11:0] L_SY   = 12'b100_100_100_010;
  localparam logic [11:0] L_RED  = 12'b100_100_100_100;
  localparam logic [11:0] L_FON  = 12'b010_010_010_100;
  localparam logic [11:0] L_DARK = 12'b000_000_000_000;

  logic clk = 1'b0;
  logic rst, side_req, ped_req, emerg, flash_en;
  logic [2:0] light_M1, light_M2, light_MT, light_S, phase;
  logic ped_walk;

  int checks = 0;
  int errors = 0;

  tlc_phase_sequencer #(
    .CNT_W(8), .T_MG(T_MG), .T_Y(T_Y), .T_TG(T_TG), .T_SG(T_SG), .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk(clk), .rst(rst), .side_req(side_req), .ped_req(ped_req), .emerg(emerg),
    .flash_en(flash_en), .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT),
    .light_S(light_S), .phase(phase), .ped_walk(ped_walk)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] lamps_for(logic [2:0] ph, logic blink);
    case (ph)
      StMg:    return L_MG;
      StM2y:   return L_M2Y;
      StTg:    return L_TG;
      StTy:    return L_TY;
      StSg:    return L_SG;
      StSy:    return L_SY;
      StFlash: return blink ? L_FON : L_DARK;
      default: return L_RED;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic r, input logic s, input logic p, input logic e,
                       input logic f);
    rst = r; side_req = s; ped_req = p; emerg = e; flash_en = f;
  endtask

  task automatic check(input string name, input logic [2:0] eph, input logic [11:0] elamps);
    logic [15:0] act, exp;
    act = {phase, light_M1, light_M2, light_MT, light_S, ped_walk};
    exp = {eph, elamps, (eph == StSg)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got phase=%0d lamps=%b walk=%b, want phase=%0d lamps=%b walk=%b",
               name, act[15:13], act[12:1], act[0], exp[15:13], exp[12:1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Reference model: phase plus cycles spent in it; blink derives from time in FLASH.
  logic [2:0] m_ph;
  int m_age;
  bit m_pend, m_timed;

  function automatic int hold_of(logic [2:0] ph);
    case (ph)
      StMg: return T_MG;
      StTg: return T_TG;
      StSg: return T_SG;
      default: return T_Y;
    endcase
  endfunction

  function automatic logic [2:0] next_of(logic [2:0] ph);
    case (ph)
      StM2y: return StTg;
      StTg: return StTy;
      StTy: return StSg;
      StSg: return StSy;
      default: return StMg;
    endcase
  endfunction

  function automatic logic model_blink();
    return ((m_age / (FLASH_HALF + 1)) % 2) == 0;
  endfunction

  task automatic model_step(input logic r, input logic s, input logic p, input logic e,
                            input logic f);
    logic [2:0] nph;
    int nage;
    bit npend, ntimed;
    if (r) begin
      m_ph = StMg; m_age = 0; m_pend = 0; m_timed = 0;
      return;
    end
    npend = m_pend | s | p;
    ntimed = 0;
    nph = m_ph;
    nage = m_age + 1;
    if (e) begin
      nph = StClr; nage = 0;
    end else if (f) begin
      nph = StFlash;
      if (m_ph != StFlash) nage = 0;
    end else if (m_ph == StFlash) begin
      nph = StClr; nage = 0; ntimed = 1;
    end else if (m_ph == StClr) begin
      if (!m_timed || m_age == T_Y) begin
        nph = StMg; nage = 0;
      end else begin
        ntimed = 1;
      end
    end else if (m_age == hold_of(m_ph)) begin
      nage = 0;
      if (m_ph == StMg) nph = m_pend ? StM2y : StMg;
      else nph = next_of(m_ph);
    end
    if (nph == StSg && m_ph != StSg) npend = s | p;
    m_ph = nph; m_age = nage; m_pend = npend; m_timed = ntimed;
  endtask

  typedef struct {
    logic r, s, p, e, f;
    logic [2:0] ph;
    logic [11:0] lamps;
  } vec_t;

  vec_t tbl[18];

  task automatic reset_with_side(input logic s);
    apply(1, s, 0, 0, 0);
    step();
    apply(0, s, 0, 0, 0);
  endtask

  initial begin
    int len, walks;
    logic [2:0] seg_ph[6];
    int seg_len[6];
    apply(0, 0, 0, 0, 0);

    // Emergency, flash blinking, timed clearance after flash.
    tbl[0]  = '{1, 0, 0, 0, 0, StMg, L_MG};
    tbl[1]  = '{0, 0, 0, 1, 0, StClr, L_RED};
    tbl[2]  = '{0, 0, 0, 1, 1, StClr, L_RED};
    tbl[3]  = '{0, 0, 0, 0, 1, StFlash, L_FON};
    tbl[4]  = '{0, 0, 0, 0, 1, StFlash, L_FON};
    tbl[5]  = '{0, 0, 0, 0, 1, StFlash, L_FON};
    tbl[6]  = '{0, 0, 0, 0, 1, StFlash, L_FON};
    tbl[7]  = '{0, 0, 0, 0, 1, StFlash, L_DARK};
    tbl[8]  = '{0, 0, 0, 0, 1, StFlash, L_DARK};
    tbl[9]  = '{0, 0, 0, 0, 1, StFlash, L_DARK};
    tbl[10] = '{0, 0, 0, 0, 1, StFlash, L_DARK};
    tbl[11] = '{0, 0, 0, 0, 1, StFlash, L_FON};
    tbl[12] = '{0, 0, 0, 0, 0, StClr, L_RED};
    tbl[13] = '{0, 0, 0, 0, 0, StClr, L_RED};
    tbl[14] = '{0, 0, 0, 0, 0, StClr, L_RED};
    tbl[15] = '{0, 0, 0, 0, 0, StMg, L_MG};
    tbl[16] = '{0, 0, 0, 1, 0, StClr, L_RED};
    tbl[17] = '{0, 0, 0, 0, 0, StMg, L_MG};
    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].e, tbl[i].f);
      step();
      check($sformatf("vec%0d", i), tbl[i].ph, tbl[i].lamps);
    end

    // Full cycle with side_req held: 8/3/6/3/4/3, two periods.
    seg_ph = '{StMg, StM2y, StTg, StTy, StSg, StSy};
    seg_len = '{8, 3, 6, 3, 4, 3};
    reset_with_side(1);
    walks = 0;
    len = 0;
    for (int per = 0; per < 2; per++) begin
      for (int sg = 0; sg < 6; sg++) begin
        for (int c = 0; c < seg_len[sg]; c++) begin
          check($sformatf("period%0d_seg%0d_c%0d", per, sg, c), seg_ph[sg],
                lamps_for(seg_ph[sg], 1'b1));
          if (per == 0) begin
            len++;
            if (ped_walk === 1'b1) walks++;
          end
          step();
        end
      end
    end
    check_int("period_len", len, 27);
    check_int("walk_cycles", walks, 4);

    // Idle 40 cycles, then a one-cycle ped pulse.
    reset_with_side(0);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step();
      check($sformatf("idle_k%0d", k), StMg, L_MG);
    end
    ped_req = 1;
    step();
    ped_req = 0;
    len = 40;
    while (phase === StMg && len < 70) begin
      step();
      len++;
    end
    check_int("ped_m2y_cycle", len, 48);
    check("ped_m2y", StM2y, L_M2Y);

    // Emergency at TG count 2.
    reset_with_side(1);
    repeat (13) step();
    check("tg_c2", StTg, L_TG);
    emerg = 1;
    step();
    check("emerg_clr", StClr, L_RED);
    emerg = 0;
    step();
    check("emerg_exit_mg", StMg, L_MG);
    len = 1;
    while (phase === StMg && len < 30) begin
      step();
      len++;
    end
    check_int("emerg_exit_mg_len", len - 1, 8);
    check("emerg_exit_m2y", StM2y, L_M2Y);

    // Reset during SG count 1 clears pend.
    reset_with_side(1);
    repeat (21) step();
    check("sg_c1", StSg, L_SG);
    apply(1, 0, 0, 0, 0);
    step();
    check("midreset_mg", StMg, L_MG);
    apply(0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      step();
      check($sformatf("midreset_hold%0d", k), StMg, L_MG);
    end

    // Random stimulus against the model.
    apply(1, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0);
    step();
    apply(0, 0, 0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(999) < 3);
      if ($urandom_range(999) < 15) emerg = ~emerg;
      if ($urandom_range(999) < 20) flash_en = ~flash_en;
      if ($urandom_range(99) < 10) side_req = ~side_req;
      ped_req = ($urandom_range(99) < 4);
      model_step(rst, side_req, ped_req, emerg, flash_en);
      step();
      check($sformatf("rand%0d", n), m_ph, lamps_for(m_ph, model_blink()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
